// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic_mm matrix multiplier.
// SYSTOLIC_SAT_EN adds the saturation classifier used by the PEs.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } mm_state_t;

  function automatic int unsigned drain_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

`ifdef SYSTOLIC_SAT_EN
  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_POS,
    SAT_NEG
  } sat_kind_t;

  // Inputs are the top two bits of a one-bit-extended sum; a mismatch means overflow.
  function automatic sat_kind_t sat_kind(input logic ext_msb, input logic msb);
    if (ext_msb == msb) return SAT_NONE;
    return ext_msb ? SAT_NEG : SAT_POS;
  endfunction
`endif

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell: registered east/south operand pass-through plus accumulator.
// SYSTOLIC_SAT_EN selects a saturating accumulator instead of wrap-around.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2 * WIDTH + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [ACC_W-1:0] o_acc
);

  logic [WIDTH-1:0]          r_a;
  logic [WIDTH-1:0]          r_b;
  logic [ACC_W-1:0]          r_acc;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_term;
  logic [ACC_W-1:0]          w_next;

  assign w_prod = $signed(i_a) * $signed(i_b);
  assign w_term = ACC_W'(w_prod);

`ifdef SYSTOLIC_SAT_EN
  logic signed [ACC_W:0] w_sum;

  assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_term[ACC_W-1], w_term};

  always_comb begin
    w_next = w_sum[ACC_W-1:0];
    case (sat_kind(w_sum[ACC_W], w_sum[ACC_W-1]))
      SAT_POS: w_next = {1'b0, {(ACC_W-1){1'b1}}};
      SAT_NEG: w_next = {1'b1, {(ACC_W-1){1'b0}}};
      default: w_next = w_sum[ACC_W-1:0];
    endcase
  end
`else
  assign w_next = r_acc + w_term;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_clr) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= w_next;
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_mm.sv
// Output-stationary NxN systolic multiplier C = A*B with internal skew and valid/ready input.
// Define SYSTOLIC_SAT_EN for saturating accumulators (default: two's-complement wrap).
module systolic_mm
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int ACC_W = 2 * WIDTH + 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  input  logic [N-1:0][WIDTH-1:0]          a_in,
  input  logic [N-1:0][WIDTH-1:0]          b_in,
  output logic [N-1:0][N-1:0][ACC_W-1:0]   res,
  output logic                             res_valid,
  output logic                             busy
);

  localparam int CNT_W = $clog2(2 * N);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(drain_len(N));

  mm_state_t        r_state;
  mm_state_t        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_clear;
  logic             w_accept;

  logic [N-1:0][WIDTH-1:0] w_a_lane;
  logic [N-1:0][WIDTH-1:0] w_b_lane;
  logic [WIDTH-1:0]        w_ah [N][N+1];
  logic [WIDTH-1:0]        w_bv [N+1][N];

  assign w_clear  = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_LOAD;
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && in_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(1)) w_next = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (start) w_next = ST_LOAD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           r_cnt <= '0;
    else if (r_state == ST_LOAD && w_accept && in_last)   r_cnt <= DRAIN_INIT;
    else if (r_state == ST_DRAIN)                         r_cnt <= r_cnt - 1'b1;
  end

  // Lane i is a shift register of i+1 stages; new beats (or zeros) enter at the LSB slice.
  for (genvar i = 0; i < N; i++) begin : g_skew
    localparam int SK_W = (i + 1) * WIDTH;
    logic [SK_W-1:0] r_ska;
    logic [SK_W-1:0] r_skb;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ska <= '0;
        r_skb <= '0;
      end else if (w_clear) begin
        r_ska <= '0;
        r_skb <= '0;
      end else begin
        r_ska <= SK_W'({r_ska, (w_accept ? a_in[i] : {WIDTH{1'b0}})});
        r_skb <= SK_W'({r_skb, (w_accept ? b_in[i] : {WIDTH{1'b0}})});
      end
    end

    assign w_a_lane[i] = r_ska[SK_W-1 -: WIDTH];
    assign w_b_lane[i] = r_skb[SK_W-1 -: WIDTH];
    assign w_ah[i][0]  = w_a_lane[i];
    assign w_bv[0][i]  = w_b_lane[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clear),
        .i_a   (w_ah[i][j]),
        .i_b   (w_bv[i][j]),
        .o_a   (w_ah[i][j+1]),
        .o_b   (w_bv[i+1][j]),
        .o_acc (res[i][j])
      );
    end
  end

endmodule

// File: tb/tb_systolic_mm.sv
// Self-checking bench for systolic_mm (N=2, WIDTH=8, ACC_W=16) against a matrix-level model.
module tb_systolic_mm;

  localparam int N     = 2;
  localparam int WIDTH = 8;
  localparam int ACC_W = 16;
  localparam int MAXK  = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic in_valid;
  logic in_ready;
  logic in_last;
  logic [N-1:0][WIDTH-1:0]        a_in;
  logic [N-1:0][WIDTH-1:0]        b_in;
  logic [N-1:0][N-1:0][ACC_W-1:0] res;
  logic res_valid;
  logic busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  bit started  = 1'b0;
  bit last_seen = 1'b0;
  int t_last   = 0;
  longint model [N][N];
  int ta [MAXK][N];
  int tb [MAXK][N];

  systolic_mm #(
    .N     (N),
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .a_in      (a_in),
    .b_in      (b_in),
    .res       (res),
    .res_valid (res_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic longint sres(input int i, input int j);
    logic signed [ACC_W-1:0] v;
    v = res[i][j];
    return longint'(v);
  endfunction

  // Running sum of C[i][j] with the accumulator's overflow rule applied after each add.
  function automatic longint fold(input longint v);
`ifdef SYSTOLIC_SAT_EN
    longint hi, lo;
    hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    lo = -(longint'(1) <<< (ACC_W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    logic signed [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return longint'(t);
`endif
  endfunction

  always @(negedge clk) begin
    bit e_rv, e_load, e_busy;
    if (rst_n && chk_en) begin
      e_rv   = last_seen && (cyc >= t_last + 2 * N - 1);
      e_load = started && !last_seen;
      e_busy = started && !e_rv;
      chk("in_ready", longint'(in_ready), longint'(e_load));
      chk("busy", longint'(busy), longint'(e_busy));
      chk("res_valid", longint'(res_valid), longint'(e_rv));
      if (e_rv && res_valid)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            chk($sformatf("res[%0d][%0d]", i, j), sres(i, j), model[i][j]);
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    started   = 1'b1;
    last_seen = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        model[i][j] = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic feed(input int K, input int bub_pct, input bit alt, input bit start_mid);
    int k;
    int guard;
    bit v, acc;
    k = 0;
    guard = 0;
    while (k < K) begin
      @(negedge clk);
      if (alt) v = (guard % 2 == 0);
      else     v = ($urandom_range(99) >= bub_pct);
      guard++;
      if (guard > 400) begin
        chk("feed_timeout", 0, 1);
        break;
      end
      in_valid = v;
      in_last  = (k == K - 1);
      for (int i = 0; i < N; i++) begin
        a_in[i] = v ? WIDTH'(ta[k][i]) : WIDTH'($urandom);
        b_in[i] = v ? WIDTH'(tb[k][i]) : WIDTH'($urandom);
      end
      start = start_mid && (k == K / 2);
      acc   = v && in_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (acc) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            model[i][j] = fold(model[i][j] + longint'(ta[k][i]) * longint'(tb[k][j]));
        if (k == K - 1) begin
          last_seen = 1'b1;
          t_last    = cyc;
        end
        k++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) chk({name, "_done_timeout"}, 0, 1);
    else            chk({name, "_latency"}, longint'(cyc - t_last), longint'(2 * N - 1));
  endtask

  task automatic load_identity();
    ta[0][0] = 1; ta[0][1] = 0; tb[0][0] = 1; tb[0][1] = 2;
    ta[1][0] = 0; ta[1][1] = 1; tb[1][0] = 3; tb[1][1] = 4;
  endtask

  task automatic pin_identity(input string name);
    chk({name, "_c00"}, sres(0, 0), 1);
    chk({name, "_c01"}, sres(0, 1), 2);
    chk({name, "_c10"}, sres(1, 0), 3);
    chk({name, "_c11"}, sres(1, 1), 4);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached at t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    a_in     = '0;
    b_in     = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_res_valid", longint'(res_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_res", longint'(res), 0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Identity, no bubbles
    load_identity();
    do_start();
    feed(2, 0, 1'b0, 1'b0);
    wait_done("ident");
    pin_identity("ident");

    // Identity with alternate-cycle bubbles
    do_start();
    feed(2, 0, 1'b1, 1'b0);
    wait_done("bubble");
    pin_identity("bubble");

    // Signed K=1
    ta[0][0] = -3; ta[0][1] = 5; tb[0][0] = 7; tb[0][1] = -2;
    do_start();
    feed(1, 0, 1'b0, 1'b0);
    wait_done("signed");
    chk("signed_c00", sres(0, 0), -21);
    chk("signed_c01", sres(0, 1), 6);
    chk("signed_c10", sres(1, 0), 35);
    chk("signed_c11", sres(1, 1), -10);

    // Overflow: three products of +16384
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) begin
        ta[k][i] = -128;
        tb[k][i] = -128;
      end
    do_start();
    feed(3, 0, 1'b0, 1'b0);
    wait_done("ovf");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
`ifdef SYSTOLIC_SAT_EN
        chk("ovf_sat_lit", sres(i, j), 32767);
`else
        chk("ovf_wrap_lit", sres(i, j), -16384);
`endif

    // Start pulsed mid-LOAD and mid-DRAIN must be ignored
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N; i++) begin
        ta[k][i] = int'($urandom_range(255)) - 128;
        tb[k][i] = int'($urandom_range(255)) - 128;
      end
    do_start();
    feed(4, 25, 1'b0, 1'b1);
    pulse_start();
    wait_done("start_ign");

    // Reset during DRAIN, then a clean run
    load_identity();
    do_start();
    feed(2, 0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    started   = 1'b0;
    last_seen = 1'b0;
    #1;
    chk("midrst_in_ready", longint'(in_ready), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_res_valid", longint'(res_valid), 0);
    chk("midrst_res", longint'(res), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_start();
    feed(2, 0, 1'b0, 1'b0);
    wait_done("after_rst");
    pin_identity("after_rst");

    // Randomized runs; each new start lands while res_valid is still high
    for (int r = 0; r < 10; r++) begin
      int K;
      K = int'($urandom_range(MAXK - 1, 1));
      for (int k = 0; k < K; k++)
        for (int i = 0; i < N; i++) begin
          ta[k][i] = int'($urandom_range(255)) - 128;
          tb[k][i] = int'($urandom_range(255)) - 128;
        end
      do_start();
      feed(K, 30, 1'b0, r[0]);
      wait_done("rand");
      repeat (int'($urandom_range(3))) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
